// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared types and constants for the RV32I pipeline writeback path.
//   XLEN       : datapath width
//   wb_sel_e   : writeback source select (2'b11 is reserved and falls back to ALU)
//   F3_*       : load funct3 encodings (size / signedness)
//   mem_wb_t   : contents of the MEM/WB pipeline register
//   wb_state_e : writeback FSM states
// ---------------------------------------------------------------------------
package rv32i_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // wb_sel is kept as a raw 2-bit field so the reserved code survives capture.
   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [4:0]      rd;
      logic [1:0]      wb_sel;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] pc_plus4;
      logic [2:0]      funct3;
   } mem_wb_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_ACTIVE    = 2'b01,
      ST_LOAD_WAIT = 2'b10
   } wb_state_e;

endpackage : rv32i_pkg

// File: rtl/wb_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data extraction: picks the addressed byte or halfword
// out of a word-aligned read and sign/zero-extends it.
//   funct3 : load size/sign encoding
//   off    : low address bits (byte offset within the word)
//   rdata  : word-aligned data from data memory
//   value  : aligned, extended load result
// ---------------------------------------------------------------------------
module load_align
   import rv32i_pkg::*;
#(
   parameter int XLEN = rv32i_pkg::XLEN
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] value
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[gi*8 +: 8];
   end

   // Halfwords ignore off[0]; a misaligned halfword just reads its aligned pair.
   assign byte_val = lane[off];
   assign half_val = {lane[{off[1], 1'b1}], lane[{off[1], 1'b0}]};

   always_comb begin
      value = rdata;
      case (funct3)
         F3_LB:   value = {{(XLEN-8){byte_val[7]}}, byte_val};
         F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_val};
         F3_LH:   value = {{(XLEN-16){half_val[15]}}, half_val};
         F3_LHU:  value = {{(XLEN-16){1'b0}}, half_val};
         default: value = rdata;
      endcase
   end

endmodule : load_align

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// RV32I writeback stage: MEM/WB pipeline register, load-response wait,
// load alignment, writeback source select and register-file write port.
//   clk, reset_n        : clock (rising edge), async active-low reset
//   mem_*               : instruction presented by the MEM stage
//   dmem_rvalid/rdata   : data-memory load response (word aligned)
//   wb_stall            : MEM/WB register is blocked on a load; upstream holds
//   rf_wn_en/rd_addr/wr_data : register-file write port (zeroed when idle)
//   instret             : 64-bit retired-instruction counter
//   load_timeout_err    : sticky flag, a load waited LOAD_TIMEOUT cycles
// ---------------------------------------------------------------------------
module wb_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN         = rv32i_pkg::XLEN,
   parameter int LOAD_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            mem_valid,
   input  logic            mem_reg_write,
   input  logic [4:0]      mem_rd_addr,
   input  logic [1:0]      mem_wb_sel,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] mem_pc_plus4,
   input  logic [2:0]      mem_funct3,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_stall,
   output logic            rf_wn_en,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] wr_data,
   output logic [63:0]     instret,
   output logic            load_timeout_err
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(LOAD_TIMEOUT);

   mem_wb_t         wb_reg;
   wb_state_e       state_reg;
   logic [7:0]      wait_cnt_reg;
   logic [7:0]      wait_cnt_next;
   logic            err_reg;
   logic [63:0]     instret_reg;

   logic            load_held;
   logic            completing;
   logic            write_en;
   logic [XLEN-1:0] load_value;
   logic [XLEN-1:0] result;

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3 (wb_reg.funct3),
      .off    (wb_reg.alu_result[1:0]),
      .rdata  (dmem_rdata),
      .value  (load_value)
   );

   // state_reg records that a load is held; whether it is still waiting or
   // completes this cycle is decided by dmem_rvalid, so a load that gets its
   // data in the first cycle behaves as ACTIVE without any extra latency.
   assign load_held  = (state_reg == ST_LOAD_WAIT);
   assign wb_stall   = load_held && !dmem_rvalid;
   assign completing = wb_reg.valid && !wb_stall;
   assign write_en   = completing && wb_reg.reg_write && (wb_reg.rd != 5'd0);

   always_comb begin
      result = wb_reg.alu_result;
      case (wb_reg.wb_sel)
         WB_LOAD: result = load_value;
         WB_PC4:  result = wb_reg.pc_plus4;
         default: result = wb_reg.alu_result;
      endcase
   end

   assign rf_wn_en         = write_en;
   assign rd_addr          = write_en ? wb_reg.rd : 5'd0;
   assign wr_data          = write_en ? result : '0;
   assign instret          = instret_reg;
   assign load_timeout_err = err_reg;

   assign wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_reg       <= '0;
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 8'd0;
         err_reg      <= 1'b0;
         instret_reg  <= 64'd0;
      end else begin
         if (completing) begin
            instret_reg <= instret_reg + 64'd1;
         end

         if (!wb_stall) begin
            wb_reg.valid      <= mem_valid;
            wb_reg.reg_write  <= mem_reg_write;
            wb_reg.rd         <= mem_rd_addr;
            wb_reg.wb_sel     <= mem_wb_sel;
            wb_reg.alu_result <= mem_alu_result;
            wb_reg.pc_plus4   <= mem_pc_plus4;
            wb_reg.funct3     <= mem_funct3;
            wait_cnt_reg      <= 8'd0;
            if (!mem_valid) begin
               state_reg <= ST_IDLE;
            end else if (mem_wb_sel == WB_LOAD) begin
               state_reg <= ST_LOAD_WAIT;
            end else begin
               state_reg <= ST_ACTIVE;
            end
         end else begin
            // Waiting cycle: count it, flag the timeout, but keep waiting.
            state_reg    <= ST_LOAD_WAIT;
            wait_cnt_reg <= wait_cnt_next;
            if (wait_cnt_next >= TIMEOUT_CNT) begin
               err_reg <= 1'b1;
            end
         end
      end
   end

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_valid, mem_reg_write;
   logic [4:0]  mem_rd_addr;
   logic [1:0]  mem_wb_sel;
   logic [31:0] mem_alu_result, mem_pc_plus4;
   logic [2:0]  mem_funct3;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_stall, rf_wn_en;
   logic [4:0]  rd_addr;
   logic [31:0] wr_data;
   logic [63:0] instret;
   logic        load_timeout_err;

   int tests  = 0;
   int failed = 0;

   wb_stage #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mem_valid        (mem_valid),
      .mem_reg_write    (mem_reg_write),
      .mem_rd_addr      (mem_rd_addr),
      .mem_wb_sel       (mem_wb_sel),
      .mem_alu_result   (mem_alu_result),
      .mem_pc_plus4     (mem_pc_plus4),
      .mem_funct3       (mem_funct3),
      .dmem_rvalid      (dmem_rvalid),
      .dmem_rdata       (dmem_rdata),
      .wb_stall         (wb_stall),
      .rf_wn_en         (rf_wn_en),
      .rd_addr          (rd_addr),
      .wr_data          (wr_data),
      .instret          (instret),
      .load_timeout_err (load_timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        v;
      bit        rw;
      bit [4:0]  rd;
      bit [1:0]  sel;
      bit [31:0] alu;
      bit [31:0] pc4;
      bit [2:0]  f3;
   } instr_t;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input instr_t t);
      mem_valid      = t.v;
      mem_reg_write  = t.rw;
      mem_rd_addr    = t.rd;
      mem_wb_sel     = t.sel;
      mem_alu_result = t.alu;
      mem_pc_plus4   = t.pc4;
      mem_funct3     = t.f3;
   endtask

   function automatic instr_t mk(bit v, bit rw, bit [4:0] rd, bit [1:0] sel,
                                 bit [31:0] alu, bit [31:0] pc4, bit [2:0] f3);
      instr_t t;
      t.v = v; t.rw = rw; t.rd = rd; t.sel = sel; t.alu = alu; t.pc4 = pc4; t.f3 = f3;
      return t;
   endfunction

   // Reference: value written back, from the ISA rules with plain arithmetic.
   function automatic bit [31:0] ref_value(instr_t t, bit [31:0] rdata);
      longint unsigned b, h;
      if (t.sel == 2'd1) begin
         b = (longint'(rdata) >> (8 * (t.alu % 4))) % 256;
         h = (longint'(rdata) >> (16 * ((t.alu / 2) % 2))) % 65536;
         case (t.f3)
            3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd5:    return 32'(h);
            default: return rdata;
         endcase
      end else if (t.sel == 2'd2) begin
         return t.pc4;
      end
      return t.alu;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   instr_t      bubble, cur, prev, junk;
   bit [31:0]   rdv;
   logic [63:0] exp_instret;
   bit          exp_en;
   int          lat;

   localparam int NLD = 4;
   bit [2:0]  ld_f3  [NLD] = '{3'd0, 3'd4, 3'd1, 3'd5};
   bit [31:0] ld_adr [NLD] = '{32'h1003, 32'h2002, 32'h3002, 32'h4000};
   bit [31:0] ld_exp [NLD] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};

   initial begin
      bubble = mk(0, 0, 0, 0, 0, 0, 0);
      drive(bubble);
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
      reset_n     = 1'b0;
      tick; tick;
      // Reset state
      check("rst_en", rf_wn_en, 0);
      check("rst_rd", rd_addr, 0);
      check("rst_data", wr_data, 0);
      check("rst_stall", wb_stall, 0);
      check("rst_instret", instret, 0);
      check("rst_err", load_timeout_err, 0);
      reset_n = 1'b1;

      // ALU op
      drive(mk(1, 1, 5, 2'd0, 32'h1234_5678, 32'h0, 3'd0));
      tick; drive(bubble); #1;
      check("alu_en", rf_wn_en, 1);
      check("alu_rd", rd_addr, 5);
      check("alu_data", wr_data, 32'h1234_5678);
      check("alu_stall", wb_stall, 0);
      tick;
      check("alu_instret", instret, 1);
      $display("[TB] txn alu rd=5 data=%h instret=%0d", 32'h1234_5678, instret);

      // rd = x0
      drive(mk(1, 1, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0));
      tick; drive(bubble); #1;
      check("x0_en", rf_wn_en, 0);
      check("x0_rd", rd_addr, 0);
      check("x0_data", wr_data, 0);
      tick;
      check("x0_instret", instret, 2);
      $display("[TB] txn x0 write instret=%0d", instret);

      // Zero-wait loads with the four extraction cases
      for (int i = 0; i < NLD; i++) begin
         drive(mk(1, 1, 7, 2'd1, ld_adr[i], 32'h0, ld_f3[i]));
         tick; drive(bubble);
         dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_7F01; #1;
         check("ld_en", rf_wn_en, 1);
         check("ld_stall", wb_stall, 0);
         check("ld_data", wr_data, ld_exp[i]);
         $display("[TB] txn load f3=%0d addr=%h data=%h", ld_f3[i], ld_adr[i], wr_data);
         tick; dmem_rvalid = 1'b0;
      end
      check("ld_instret", instret, 6);

      // PC+4 source
      drive(mk(1, 1, 1, 2'd2, 32'h55, 32'h0000_0104, 3'd0));
      tick; drive(bubble); #1;
      check("pc4_data", wr_data, 32'h104);
      $display("[TB] txn pc4 data=%h", wr_data);
      tick;

      // Load wait of 3 cycles with the next instruction waiting upstream
      drive(mk(1, 1, 9, 2'd1, 32'h0, 32'h0, 3'd2));
      tick;
      drive(mk(1, 1, 10, 2'd0, 32'hAAAA_5555, 32'h0, 3'd0));
      for (int k = 0; k < 3; k++) begin
         dmem_rvalid = 1'b0; dmem_rdata = 32'h1111_1111; #1;
         check("wait_stall", wb_stall, 1);
         check("wait_en", rf_wn_en, 0);
         tick;
      end
      dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_BABE; #1;
      check("wait_done_en", rf_wn_en, 1);
      check("wait_done_rd", rd_addr, 9);
      check("wait_done_data", wr_data, 32'hCAFE_BABE);
      check("wait_done_stall", wb_stall, 0);
      $display("[TB] txn load-wait rd=9 data=%h", wr_data);
      tick; drive(bubble); dmem_rvalid = 1'b0; #1;
      check("next_rd", rd_addr, 10);
      check("next_data", wr_data, 32'hAAAA_5555);
      $display("[TB] txn alu after wait rd=%0d data=%h", rd_addr, wr_data);
      tick;
      check("wait_instret", instret, 9);

      // Timeout (LOAD_TIMEOUT=4)
      check("to_err_before", load_timeout_err, 0);
      drive(mk(1, 1, 3, 2'd1, 32'h0, 32'h0, 3'd2));
      tick; drive(bubble);
      for (int k = 1; k <= 6; k++) begin
         dmem_rvalid = 1'b0; #1;
         check("to_err", load_timeout_err, (k >= 5) ? 1 : 0);
         check("to_stall", wb_stall, 1);
         tick;
      end
      dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0042; #1;
      check("to_done_en", rf_wn_en, 1);
      check("to_done_data", wr_data, 32'h42);
      tick; dmem_rvalid = 1'b0;
      check("to_err_sticky", load_timeout_err, 1);
      $display("[TB] txn timeout load err=%0d", load_timeout_err);

      // Asynchronous reset in the middle of a load wait
      drive(mk(1, 1, 4, 2'd1, 32'h0, 32'h0, 3'd2));
      tick; drive(bubble); #1;
      check("rw_stall_pre", wb_stall, 1);
      @(posedge clk); #3;
      reset_n = 1'b0; dmem_rvalid = 1'b1; #1;
      check("rw_en", rf_wn_en, 0);
      check("rw_stall", wb_stall, 0);
      check("rw_instret", instret, 0);
      check("rw_err", load_timeout_err, 0);
      tick;
      reset_n = 1'b1; dmem_rvalid = 1'b0;
      tick;
      check("rw_post_en", rf_wn_en, 0);
      check("rw_post_stall", wb_stall, 0);
      check("rw_post_instret", instret, 0);
      $display("[TB] txn reset mid-wait instret=%0d", instret);

      // Randomized pipeline traffic against the reference model
      exp_instret = 64'd0;
      prev = bubble;
      for (int i = 0; i <= 120; i++) begin
         if (i == 120) cur = bubble;
         else cur = mk($urandom_range(0, 9) != 0, 1'($urandom), 5'($urandom),
                       2'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom));
         rdv = $urandom;
         drive(cur);
         dmem_rvalid = (prev.v && prev.sel == 2'd1) ? 1'b1 : 1'($urandom);
         dmem_rdata  = rdv;
         #1;
         check("rnd_stall", wb_stall, 0);
         check("rnd_instret", instret, exp_instret);
         if (prev.v) begin
            exp_en = prev.rw && (prev.rd != 0);
            check("rnd_en", rf_wn_en, exp_en);
            check("rnd_rd", rd_addr, exp_en ? prev.rd : 5'd0);
            check("rnd_data", wr_data, exp_en ? ref_value(prev, rdv) : 32'd0);
            exp_instret++;
         end else begin
            check("rnd_bubble_en", rf_wn_en, 0);
         end
         $display("[TB] txn rnd %0d v=%0d sel=%0d rd=%0d en=%0d data=%h", i, prev.v,
                  prev.sel, prev.rd, rf_wn_en, wr_data);
         tick;
         if (cur.v && cur.sel == 2'd1) begin
            lat = $urandom_range(0, 3);
            for (int k = 0; k < lat; k++) begin
               junk = mk(1, 1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom,
                         3'($urandom));
               drive(junk);
               dmem_rvalid = 1'b0; dmem_rdata = $urandom; #1;
               check("rnd_wait_stall", wb_stall, 1);
               check("rnd_wait_en", rf_wn_en, 0);
               tick;
            end
         end
         prev = cur;
      end
      check("rnd_final_instret", instret, exp_instret);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I 5-stage pipeline: the writer side of the register file.
- Holds the MEM/WB pipeline register and waits on the data-memory load response.
- Aligns and sign/zero-extends load data, selects the writeback source, and drives the register-file write port (rf_wn_en, rd_addr, wr_data).
- Also provides a writeback stall to upstream stages and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- LOAD_TIMEOUT, 255, max cycles waited for dmem_rvalid before the sticky error flag sets (8-bit wait counter).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_reg_write  in  1  instruction writes rd.
- mem_rd_addr  in  5  destination register.
- mem_wb_sel  in  2  writeback source: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU).
- mem_alu_result  in  XLEN  ALU result / effective address.
- mem_pc_plus4  in  XLEN  link value.
- mem_funct3  in  3  load size/sign.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  word-aligned load data.
- wb_stall  out  1  MEM/WB register cannot accept; upstream holds.
- rf_wn_en  out  1  register-file write enable.
- rd_addr  out  5  register-file write address.
- wr_data  out  XLEN  register-file write data.
- instret  out  64  retired-instruction count.
- load_timeout_err  out  1  sticky, wait exceeded LOAD_TIMEOUT.

Behaviour:
- Reset (async, reset_n low): MEM/WB register valid=0, all fields 0, FSM=IDLE, instret=0, wait counter=0, load_timeout_err=0. Outputs during reset: rf_wn_en=0, rd_addr=0, wr_data=0, wb_stall=0.
- Capture: on posedge, if !wb_stall, the register loads all mem_* fields and valid<=mem_valid. If wb_stall, it holds.
- FSM states IDLE, ACTIVE, LOAD_WAIT:
  - IDLE: register empty.
  - ACTIVE: register holds a non-load, or a load whose data arrives this cycle.
  - LOAD_WAIT: load held, dmem_rvalid low.
  - Next state follows from the captured instruction and dmem_rvalid. LOAD_WAIT->ACTIVE is implicit: the load completes in the cycle dmem_rvalid=1.
- Output timing: outputs are combinational from the register. The instruction captured at edge N completes in cycle N+1 when non-load or dmem_rvalid=1, giving zero-wait loads. Otherwise it completes in the first cycle dmem_rvalid=1.
- wb_stall = valid && wb_sel==LOAD && !dmem_rvalid.
- rf_wn_en = valid && reg_write && rd!=0 && completing. rd_addr=0 and wr_data=0 when rf_wn_en=0.
- Load extract uses off=alu_result[1:0]:
  - funct3 000 LB: sext byte at off.
  - 100 LBU: zext byte at off.
  - 001 LH: sext halfword at alu_result[1]*16.
  - 101 LHU: zext halfword at alu_result[1]*16.
  - 010 LW and 011/110/111: full word.
  - off[0] is ignored for halfwords; misalignment is not trapped here.
- instret increments by 1 in every cycle an instruction completes, including rd=x0 and reg_write=0. It wraps at 2^64-1 -> 0.
- Wait counter: clears on entering LOAD_WAIT and increments each LOAD_WAIT cycle, saturating. When it reaches LOAD_TIMEOUT, load_timeout_err sets and stays set until reset. The stage keeps waiting.
- dmem_rvalid is ignored unless a load is held.
- Reset mid-LOAD_WAIT: the instruction is dropped, with no write and no instret increment.

Decomposition:
- Package rv32i_pkg holds:
  - typedef wb_sel_e {WB_ALU, WB_LOAD, WB_PC4}.
  - funct3 load constants F3_LB/LH/LW/LBU/LHU.
  - struct mem_wb_t for the register fields.
  - XLEN.
- One sub-module, load_align: combinational byte/halfword extract and extension (funct3, off, rdata -> value).

Test Plan:
- ALU op: mem_valid=1, rd=5, ALU=0x1234_5678 -> next cycle rf_wn_en=1, rd_addr=5, wr_data=0x12345678; instret=1.
- rd=x0 write: rd=0, reg_write=1 -> rf_wn_en=0, instret still increments.
- LB sign: rdata=0x80FF_7F01, addr off=3 -> wr_data=0xFFFFFF80. LBU off=2 -> 0x000000FF. LH off=2 -> 0xFFFF80FF. LHU off=0 -> 0x00007F01.
- Load wait: load captured, dmem_rvalid low 3 cycles -> wb_stall=1 for 3 cycles, register holds, next MEM instruction not captured. Then rvalid=1 -> write in that cycle, wb_stall=0, next instruction captured at that edge.
- Timeout: LOAD_TIMEOUT=4, rvalid held low 6 cycles -> load_timeout_err rises after the 4th wait cycle and stays 1 after the load completes.
- Reset in LOAD_WAIT: assert reset_n=0 asynchronously mid-wait -> rf_wn_en=0, wb_stall=0, instret=0 immediately. After release, IDLE with no write.
